// File: rtl/fwd_pkg.sv
// Shared forwarding types: operand-select codes, the in-flight destination tag,
// and the "tag writes register" predicate used by hazard and select logic.
package fwd_pkg;

  localparam int FWD_REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } fwd_tag_t;

  // x0 is hardwired zero, so a producer targeting it never matches.
  function automatic logic tag_writes(input fwd_tag_t t, input logic [FWD_REG_AW-1:0] r);
    return t.valid && t.reg_write && (t.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// ID/EX -> EX/MEM -> MEM/WB destination-tag shift register; a bubble
// replaces the incoming ID tag with an invalid tag.
module fwd_tag_pipe
  import fwd_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     bubble,
  input  fwd_tag_t id_tag,
  output fwd_tag_t t_ex,
  output fwd_tag_t t_mem,
  output fwd_tag_t t_wb
);

  fwd_tag_t t_ex_q, t_mem_q, t_wb_q;
  fwd_tag_t t_ex_d, t_mem_d, t_wb_d;

  always_comb begin
    t_ex_d  = id_tag;
    t_mem_d = t_ex_q;
    t_wb_d  = t_mem_q;
    if (bubble) t_ex_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_ex_q  <= '0;
      t_mem_q <= '0;
      t_wb_q  <= '0;
    end else begin
      t_ex_q  <= t_ex_d;
      t_mem_q <= t_mem_d;
      t_wb_q  <= t_wb_d;
    end
  end

  assign t_ex  = t_ex_q;
  assign t_mem = t_mem_q;
  assign t_wb  = t_wb_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand-forward selects, load-use stall/bubble and stall counter.
// Optional FWD_STALL_COUNT_EN enables the saturating stall counter.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW = FWD_REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_flush,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_count
);

  fwd_tag_t id_tag, t_ex, t_mem, t_wb;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic load_use;

  assign id_tag = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write,
                    mem_read: id_mem_read};

  fwd_tag_pipe u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .bubble (bubble),
    .id_tag (id_tag),
    .t_ex   (t_ex),
    .t_mem  (t_mem),
    .t_wb   (t_wb)
  );

  // MEM/WB tag and the load flag past EX are tracked but not consulted here.
  logic unused_tags;
  assign unused_tags = ^{t_wb, t_mem.mem_read};

  always_comb begin
    load_use = id_valid && !ex_flush && t_ex.mem_read &&
               ((id_use_rs1 && tag_writes(t_ex, id_rs1)) ||
                (id_use_rs2 && tag_writes(t_ex, id_rs2)));
    stall  = load_use && !rst;
    bubble = (load_use || ex_flush) && !rst;
  end

  // Checked against the instruction one ahead (t_ex), which will sit in
  // EX/MEM when this consumer reaches EX; newest producer wins.
  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!bubble) begin
      if (id_use_rs1 && tag_writes(t_ex, id_rs1))       fwd_a_d = FWD_MEM;
      else if (id_use_rs1 && tag_writes(t_mem, id_rs1)) fwd_a_d = FWD_WB;
      if (id_use_rs2 && tag_writes(t_ex, id_rs2))       fwd_b_d = FWD_MEM;
      else if (id_use_rs2 && tag_writes(t_mem, id_rs2)) fwd_b_d = FWD_WB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign forwardA = fwd_a_q;
  assign forwardB = fwd_b_q;

`ifdef FWD_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_count_q <= '0;
    else     stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

endmodule
